// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel-to-serial stage that feeds the sequence detector.
// One word can wait in a holding register while another is being shifted out,
// so words offered back to back leave as one continuous bit stream. Every
// output is a decode of registered state; word_done also depends on bit_en.
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             bit_en,
  output logic             x_out,
  output logic             x_valid,
  output logic             first_bit,
  output logic             word_done,
  output logic             busy
);

  localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] hold_q;
  logic [CNT_W-1:0] cnt_q;
  logic             hold_full_q;

  logic             accept_d;
  logic             shifting_d;
  logic             last_bit_d;
  logic [WIDTH-1:0] sreg_shift_d;

  // Decode the handshake and the next shifted value from the current state.
  always_comb begin
    accept_d     = in_valid & ~hold_full_q;
    shifting_d   = (state_q == SHIFT);
    last_bit_d   = shifting_d & (cnt_q == CNT_LAST);
    sreg_shift_d = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);
  end

  // in_ready looks only at the holding register, so there is no path from in_valid.
  assign in_ready  = ~hold_full_q;
  assign x_valid   = shifting_d;
  assign x_out     = shifting_d & (LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1]);
  assign first_bit = shifting_d & (cnt_q == '0);
  assign word_done = last_bit_d & bit_en;
  assign busy      = shifting_d | hold_full_q;

  // Holding register, shifter and state machine. An accept only happens with
  // the holding register empty and a transfer only with it full, so the two
  // writes to hold_full_q never land on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      if (accept_d) begin
        hold_q      <= in_data;
        hold_full_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (hold_full_q) begin
            sreg_q      <= hold_q;
            cnt_q       <= '0;
            hold_full_q <= 1'b0;
            state_q     <= SHIFT;
          end
        end

        SHIFT: begin
          if (bit_en) begin
            if (cnt_q == CNT_LAST) begin
              if (hold_full_q) begin
                // Reload on the last bit so the next word follows with no gap.
                sreg_q      <= hold_q;
                cnt_q       <= '0;
                hold_full_q <= 1'b0;
              end else begin
                sreg_q  <= '0;
                cnt_q   <= '0;
                state_q <= IDLE;
              end
            end else begin
              sreg_q <= sreg_shift_d;
              cnt_q  <= cnt_q + CNT_W'(1);
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Self-checking bench for serial_bit_feeder. Two instances share all inputs:
// one shifts MSB first, the other LSB first. Directed words cover the basic
// ordering and boundary cases; a randomized run compares both serial streams
// against a queue of the bits of every accepted word.
module tb_serial_bit_feeder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         bit_en;

  logic m_in_ready, m_x_out, m_x_valid, m_first_bit, m_word_done, m_busy;
  logic l_in_ready, l_x_out, l_x_valid, l_first_bit, l_word_done, l_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_bit_feeder #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(m_in_ready), .bit_en(bit_en), .x_out(m_x_out), .x_valid(m_x_valid),
    .first_bit(m_first_bit), .word_done(m_word_done), .busy(m_busy)
  );

  serial_bit_feeder #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(l_in_ready), .bit_en(bit_en), .x_out(l_x_out), .x_valid(l_x_valid),
    .first_bit(l_first_bit), .word_done(l_word_done), .busy(l_busy)
  );

  // Inputs change and outputs are read at the falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; bit_en = 1'b1; in_data = '0;
    @(negedge clk);
    #1;
    checks++; if (m_x_out !== 1'b0) begin failures++; $display("FAIL reset x_out got=%b exp=0", m_x_out); end
    checks++; if (m_x_valid !== 1'b0) begin failures++; $display("FAIL reset x_valid got=%b exp=0", m_x_valid); end
    checks++; if (m_first_bit !== 1'b0) begin failures++; $display("FAIL reset first_bit got=%b exp=0", m_first_bit); end
    checks++; if (m_word_done !== 1'b0) begin failures++; $display("FAIL reset word_done got=%b exp=0", m_word_done); end
    checks++; if (m_busy !== 1'b0) begin failures++; $display("FAIL reset busy got=%b exp=0", m_busy); end
    checks++; if (m_in_ready !== 1'b1) begin failures++; $display("FAIL reset in_ready got=%b exp=1", m_in_ready); end
    checks++; if (l_x_valid !== 1'b0 || l_in_ready !== 1'b1) begin failures++; $display("FAIL reset lsb x_valid/in_ready got=%b/%b exp=0/1", l_x_valid, l_in_ready); end
    cycle();
    reset = 1'b0;
    cycle();
    $display("test_reset: done");
  endtask

  task automatic test_msb_word();
    logic [W-1:0] w;
    w = 8'hB2;
    in_data = w; in_valid = 1'b1; bit_en = 1'b1;
    cycle();
    in_valid = 1'b0;
    checks++; if (m_x_valid !== 1'b0) begin failures++; $display("FAIL msb_word latency x_valid got=%b exp=0", m_x_valid); end
    checks++; if (m_in_ready !== 1'b0 || m_busy !== 1'b1) begin failures++; $display("FAIL msb_word held in_ready/busy got=%b/%b exp=0/1", m_in_ready, m_busy); end
    for (int i = 0; i < W; i++) begin
      cycle();
      checks++; if (m_x_valid !== 1'b1) begin failures++; $display("FAIL msb_word bit%0d x_valid got=%b exp=1", i, m_x_valid); end
      checks++; if (m_x_out !== w[W-1-i]) begin failures++; $display("FAIL msb_word bit%0d x_out got=%b exp=%b", i, m_x_out, w[W-1-i]); end
      checks++; if (m_first_bit !== (i == 0)) begin failures++; $display("FAIL msb_word bit%0d first_bit got=%b exp=%b", i, m_first_bit, (i == 0)); end
      checks++; if (m_word_done !== (i == W-1)) begin failures++; $display("FAIL msb_word bit%0d word_done got=%b exp=%b", i, m_word_done, (i == W-1)); end
      checks++; if (l_x_out !== w[i]) begin failures++; $display("FAIL msb_word lsb_dut bit%0d x_out got=%b exp=%b", i, l_x_out, w[i]); end
    end
    cycle();
    checks++; if (m_x_valid !== 1'b0 || m_x_out !== 1'b0) begin failures++; $display("FAIL msb_word after x_valid/x_out got=%b/%b exp=0/0", m_x_valid, m_x_out); end
    checks++; if (m_busy !== 1'b0 || m_in_ready !== 1'b1) begin failures++; $display("FAIL msb_word after busy/in_ready got=%b/%b exp=0/1", m_busy, m_in_ready); end
    $display("test_msb_word: word 0x%02h", w);
  endtask

  task automatic test_back_to_back();
    logic exp_bit;
    logic exp_rdy;
    in_data = 8'hFF; in_valid = 1'b1; bit_en = 1'b1;
    cycle();
    checks++; if (m_in_ready !== 1'b0) begin failures++; $display("FAIL b2b after_accept1 in_ready got=%b exp=0", m_in_ready); end
    in_data = 8'h00;
    cycle();
    for (int i = 0; i < 2*W; i++) begin
      exp_bit = (i < W);
      exp_rdy = !(i >= 1 && i <= W-1);
      checks++; if (m_x_valid !== 1'b1) begin failures++; $display("FAIL b2b bit%0d x_valid got=%b exp=1", i, m_x_valid); end
      checks++; if (m_x_out !== exp_bit) begin failures++; $display("FAIL b2b bit%0d x_out got=%b exp=%b", i, m_x_out, exp_bit); end
      checks++; if (m_in_ready !== exp_rdy) begin failures++; $display("FAIL b2b bit%0d in_ready got=%b exp=%b", i, m_in_ready, exp_rdy); end
      checks++; if (m_first_bit !== (i % W == 0)) begin failures++; $display("FAIL b2b bit%0d first_bit got=%b exp=%b", i, m_first_bit, (i % W == 0)); end
      if (i == 1) in_valid = 1'b0;
      cycle();
    end
    checks++; if (m_x_valid !== 1'b0) begin failures++; $display("FAIL b2b after x_valid got=%b exp=0", m_x_valid); end
    $display("test_back_to_back: words 0xff 0x00");
  endtask

  task automatic test_bit_en_pattern();
    logic [W-1:0] w;
    w = 8'hC3;
    in_data = w; in_valid = 1'b1; bit_en = 1'b0;
    cycle();
    in_valid = 1'b0;
    cycle();
    for (int k = 0; k < 2*W; k++) begin
      bit_en = (k % 2 == 1);
      #1;
      checks++; if (m_x_valid !== 1'b1) begin failures++; $display("FAIL bit_en k%0d x_valid got=%b exp=1", k, m_x_valid); end
      checks++; if (m_x_out !== w[W-1-k/2]) begin failures++; $display("FAIL bit_en k%0d x_out got=%b exp=%b", k, m_x_out, w[W-1-k/2]); end
      checks++; if (m_first_bit !== (k < 2)) begin failures++; $display("FAIL bit_en k%0d first_bit got=%b exp=%b", k, m_first_bit, (k < 2)); end
      checks++; if (m_word_done !== (k == 2*W-1)) begin failures++; $display("FAIL bit_en k%0d word_done got=%b exp=%b", k, m_word_done, (k == 2*W-1)); end
      cycle();
    end
    checks++; if (m_x_valid !== 1'b0) begin failures++; $display("FAIL bit_en after x_valid got=%b exp=0", m_x_valid); end
    bit_en = 1'b1;
    $display("test_bit_en_pattern: word 0x%02h", w);
  endtask

  task automatic test_lsb_word();
    in_data = 8'h01; in_valid = 1'b1; bit_en = 1'b1;
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      cycle();
      checks++; if (l_x_out !== (i == 0)) begin failures++; $display("FAIL lsb_word bit%0d x_out got=%b exp=%b", i, l_x_out, (i == 0)); end
      checks++; if (l_first_bit !== (i == 0)) begin failures++; $display("FAIL lsb_word bit%0d first_bit got=%b exp=%b", i, l_first_bit, (i == 0)); end
      checks++; if (l_word_done !== (i == W-1)) begin failures++; $display("FAIL lsb_word bit%0d word_done got=%b exp=%b", i, l_word_done, (i == W-1)); end
      checks++; if (m_x_out !== (i == W-1)) begin failures++; $display("FAIL lsb_word msb_dut bit%0d x_out got=%b exp=%b", i, m_x_out, (i == W-1)); end
    end
    cycle();
    checks++; if (l_x_valid !== 1'b0) begin failures++; $display("FAIL lsb_word after x_valid got=%b exp=0", l_x_valid); end
    $display("test_lsb_word: word 0x01");
  endtask

  task automatic test_reset_mid_word();
    logic [W-1:0] w;
    in_data = 8'hA5; in_valid = 1'b1; bit_en = 1'b1;
    cycle();              // A5 accepted
    in_data = 8'h3C;
    cycle();              // A5 moved to the shifter
    cycle();              // 3C accepted, first A5 bit consumed
    in_valid = 1'b0;
    cycle();
    cycle();              // three A5 bits consumed
    checks++; if (m_busy !== 1'b1 || m_in_ready !== 1'b0) begin failures++; $display("FAIL mid_reset pre busy/in_ready got=%b/%b exp=1/0", m_busy, m_in_ready); end
    reset = 1'b1;
    #1;
    checks++; if (m_x_valid !== 1'b0 || m_x_out !== 1'b0) begin failures++; $display("FAIL mid_reset x_valid/x_out got=%b/%b exp=0/0", m_x_valid, m_x_out); end
    checks++; if (m_in_ready !== 1'b1 || m_busy !== 1'b0) begin failures++; $display("FAIL mid_reset in_ready/busy got=%b/%b exp=1/0", m_in_ready, m_busy); end
    checks++; if (l_x_valid !== 1'b0 || l_busy !== 1'b0) begin failures++; $display("FAIL mid_reset lsb x_valid/busy got=%b/%b exp=0/0", l_x_valid, l_busy); end
    @(negedge clk);
    reset = 1'b0;
    cycle();
    checks++; if (m_x_valid !== 1'b0 || m_busy !== 1'b0) begin failures++; $display("FAIL mid_reset released x_valid/busy got=%b/%b exp=0/0", m_x_valid, m_busy); end
    w = 8'h81;
    in_data = w; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < W; i++) begin
      cycle();
      checks++; if (m_x_valid !== 1'b1 || m_x_out !== w[W-1-i]) begin failures++; $display("FAIL mid_reset next bit%0d x_valid/x_out got=%b/%b exp=1/%b", i, m_x_valid, m_x_out, w[W-1-i]); end
      checks++; if (m_first_bit !== (i == 0)) begin failures++; $display("FAIL mid_reset next bit%0d first_bit got=%b exp=%b", i, m_first_bit, (i == 0)); end
    end
    cycle();
    checks++; if (m_x_valid !== 1'b0) begin failures++; $display("FAIL mid_reset stale word x_valid got=%b exp=0", m_x_valid); end
    $display("test_reset_mid_word: discarded 0xa5/0x3c, streamed 0x81");
  endtask

  task automatic test_random();
    bit qm[$];
    bit ql[$];
    bit exp_b;
    int pos_m = 0;
    int pos_l = 0;
    int accepts = 0;
    int done_m = 0;
    int done_l = 0;
    for (int cyc = 0; cyc < 10040; cyc++) begin
      if (cyc < 10000) begin
        in_valid = ($urandom_range(0, 1) == 1);
        in_data  = W'($urandom);
        bit_en   = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid = 1'b0;
        bit_en   = 1'b1;
      end
      #1;
      checks++; if (l_in_ready !== m_in_ready) begin failures++; $display("FAIL rand c%0d lsb in_ready got=%b exp=%b", cyc, l_in_ready, m_in_ready); end
      // MSB-first instance
      if (m_x_valid) begin
        checks++; if (m_first_bit !== (pos_m == 0)) begin failures++; $display("FAIL rand c%0d msb first_bit got=%b exp=%b", cyc, m_first_bit, (pos_m == 0)); end
        if (bit_en) begin
          checks++;
          if (qm.size() == 0) begin
            failures++; $display("FAIL rand c%0d msb extra bit got=%b exp=none", cyc, m_x_out);
          end else begin
            exp_b = qm.pop_front();
            if (m_x_out !== exp_b) begin failures++; $display("FAIL rand c%0d msb x_out got=%b exp=%b", cyc, m_x_out, exp_b); end
          end
          checks++; if (m_word_done !== (pos_m == W-1)) begin failures++; $display("FAIL rand c%0d msb word_done got=%b exp=%b", cyc, m_word_done, (pos_m == W-1)); end
          if (m_word_done) done_m++;
          pos_m = (pos_m + 1) % W;
        end
      end else begin
        checks++; if (m_x_out !== 1'b0 || m_word_done !== 1'b0) begin failures++; $display("FAIL rand c%0d msb idle x_out/word_done got=%b/%b exp=0/0", cyc, m_x_out, m_word_done); end
      end
      // LSB-first instance
      if (l_x_valid) begin
        checks++; if (l_first_bit !== (pos_l == 0)) begin failures++; $display("FAIL rand c%0d lsb first_bit got=%b exp=%b", cyc, l_first_bit, (pos_l == 0)); end
        if (bit_en) begin
          checks++;
          if (ql.size() == 0) begin
            failures++; $display("FAIL rand c%0d lsb extra bit got=%b exp=none", cyc, l_x_out);
          end else begin
            exp_b = ql.pop_front();
            if (l_x_out !== exp_b) begin failures++; $display("FAIL rand c%0d lsb x_out got=%b exp=%b", cyc, l_x_out, exp_b); end
          end
          if (l_word_done) done_l++;
          pos_l = (pos_l + 1) % W;
        end
      end else begin
        checks++; if (l_x_out !== 1'b0 || l_word_done !== 1'b0) begin failures++; $display("FAIL rand c%0d lsb idle x_out/word_done got=%b/%b exp=0/0", cyc, l_x_out, l_word_done); end
      end
      // A word offered while ready is accepted at the coming edge.
      if (in_valid && m_in_ready) begin
        accepts++;
        for (int b = W-1; b >= 0; b--) qm.push_back(in_data[b]);
        for (int b = 0; b < W; b++) ql.push_back(in_data[b]);
      end
      cycle();
    end
    checks++; if (qm.size() != 0 || ql.size() != 0) begin failures++; $display("FAIL rand leftover bits got=%0d/%0d exp=0/0", qm.size(), ql.size()); end
    checks++; if (done_m != accepts) begin failures++; $display("FAIL rand msb word_done count got=%0d exp=%0d", done_m, accepts); end
    checks++; if (done_l != accepts) begin failures++; $display("FAIL rand lsb word_done count got=%0d exp=%0d", done_l, accepts); end
    checks++; if (m_x_valid !== 1'b0 || m_busy !== 1'b0) begin failures++; $display("FAIL rand drained x_valid/busy got=%b/%b exp=0/0", m_x_valid, m_busy); end
    $display("test_random: %0d words accepted", accepts);
  endtask

  initial begin
    test_reset();
    test_msb_word();
    test_back_to_back();
    test_bit_en_pattern();
    test_lsb_word();
    test_reset_mid_word();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
